// File: rtl/ds1302_burst_reader.sv
// ds1302_burst_reader: periodic DS1302 clock-burst read with masked BCD snapshot registers
module ds1302_burst_reader #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int SCLK_HZ = 500_000,
   parameter int POLL_HZ = 10
) (
   input  logic       clk,
   input  logic       rst,
   output logic       ce,
   output logic       sclk,
   output logic       io_out,
   output logic       io_oe,
   input  logic       io_in,
   output logic [7:0] secData,
   output logic [7:0] minData,
   output logic [7:0] hrsData,
   output logic [7:0] dateData,
   output logic [7:0] monData,
   output logic [7:0] dayData,
   output logic [7:0] yrData,
   output logic       rtcValid
);
   localparam int HALF   = CLK_HZ / (2 * SCLK_HZ);
   localparam int PERIOD = CLK_HZ / POLL_HZ;
   localparam int HW     = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [HW-1:0] HLAST    = HW'(HALF - 1);
   localparam logic [PW-1:0] PLAST    = PW'(PERIOD - 1);
   localparam logic [7:0]    CMD_BYTE = 8'hBF;

   typedef enum logic [2:0] {IDLE, SETUP, CMD, READ, HOLD, RECOVER} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [6:0]    hidx_q, hidx_d, hlast;
   logic [63:0]   sr_q, sr_d;
   logic          tick, half_end, phase_end, load;
   logic          ce_q, ce_d, sclk_q, sclk_d, io_out_q, io_out_d, io_oe_q, io_oe_d, valid_q, valid_d;
   logic [7:0]    sec_q, sec_d, min_q, min_d, hrs_q, hrs_d, date_q, date_d;
   logic [7:0]    mon_q, mon_d, day_q, day_d, yr_q, yr_d;

   // Poll timer, phase sequencing by half-periods, bit capture and next values of all outputs
   always_comb begin
      tick      = pcnt_q == PLAST;
      pcnt_d    = tick ? '0 : pcnt_q + PW'(1);
      half_end  = hcnt_q == HLAST;
      hlast     = state_q == CMD ? 7'd15 : state_q == READ ? 7'd127 : state_q == HOLD ? 7'd1 : 7'd3;
      phase_end = state_q != IDLE && half_end && hidx_q == hlast;
      state_d   = state_q;
      hcnt_d    = half_end ? '0 : hcnt_q + HW'(1);
      hidx_d    = half_end ? hidx_q + 7'd1 : hidx_q;
      if (state_q == IDLE) begin
         hcnt_d  = '0;
         hidx_d  = '0;
         state_d = tick ? SETUP : IDLE;
      end else if (phase_end) begin
         hidx_d  = '0;
         state_d = state_q == RECOVER ? IDLE : state_t'(state_q + 3'd1);
      end
      sr_d     = (state_q == READ && !hidx_q[0] && half_end) ? {io_in, sr_q[63:1]} : sr_q;
      load     = state_q == HOLD && phase_end;
      valid_d  = load;
      ce_d     = state_d inside {SETUP, CMD, READ, HOLD};
      sclk_d   = (state_d == CMD || state_d == READ) && hidx_d[0];
      io_oe_d  = state_d == CMD;
      io_out_d = state_d == CMD && CMD_BYTE[hidx_d[3:1]];
      sec_d    = load ? {1'b0, sr_q[6:0]}   : sec_q;
      min_d    = load ? {1'b0, sr_q[14:8]}  : min_q;
      hrs_d    = load ? {2'b0, sr_q[21:16]} : hrs_q;
      date_d   = load ? {2'b0, sr_q[29:24]} : date_q;
      mon_d    = load ? {3'b0, sr_q[36:32]} : mon_q;
      day_d    = load ? {5'b0, sr_q[42:40]} : day_q;
      yr_d     = load ? sr_q[55:48]         : yr_q;
   end

   // All state and outputs registered; reset drops the bus lines immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         pcnt_q   <= '0;
         hcnt_q   <= '0;
         hidx_q   <= '0;
         sr_q     <= '0;
         ce_q     <= 1'b0;
         sclk_q   <= 1'b0;
         io_out_q <= 1'b0;
         io_oe_q  <= 1'b0;
         valid_q  <= 1'b0;
         sec_q    <= '0;
         min_q    <= '0;
         hrs_q    <= '0;
         date_q   <= '0;
         mon_q    <= '0;
         day_q    <= '0;
         yr_q     <= '0;
      end else begin
         state_q  <= state_d;
         pcnt_q   <= pcnt_d;
         hcnt_q   <= hcnt_d;
         hidx_q   <= hidx_d;
         sr_q     <= sr_d;
         ce_q     <= ce_d;
         sclk_q   <= sclk_d;
         io_out_q <= io_out_d;
         io_oe_q  <= io_oe_d;
         valid_q  <= valid_d;
         sec_q    <= sec_d;
         min_q    <= min_d;
         hrs_q    <= hrs_d;
         date_q   <= date_d;
         mon_q    <= mon_d;
         day_q    <= day_d;
         yr_q     <= yr_d;
      end
   end

   assign ce       = ce_q;
   assign sclk     = sclk_q;
   assign io_out   = io_out_q;
   assign io_oe    = io_oe_q;
   assign rtcValid = valid_q;
   assign secData  = sec_q;
   assign minData  = min_q;
   assign hrsData  = hrs_q;
   assign dateData = date_q;
   assign monData  = mon_q;
   assign dayData  = day_q;
   assign yrData   = yr_q;
endmodule
